// File: rtl/demux_stream.sv
// demux_stream
//   Registered 1-to-CHANNELS stream demultiplexer with valid/ready handshakes.
//   Each input word goes either to the channel selected by in_key or, when
//   in_broadcast is set, to every channel at once. Each output channel has a
//   single-entry register. There is no input buffering.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-high reset
//   enable         gates acceptance of new input words; output slots still drain
//   in_data        input word
//   in_key         destination channel index (ignored on broadcast)
//   in_broadcast   deliver the word to every channel
//   in_valid       producer offers a word
//   in_ready       word is accepted this cycle (combinational, independent of in_valid)
//   out_data       channel i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid      channel i holds a word
//   out_ready      consumer i takes its word
//   accepted_count number of accepted input transfers, wraps around
module demux_stream #(
    parameter int DATA_WIDTH  = 8,
    parameter int SEL_WIDTH   = 3,
    parameter int COUNT_WIDTH = 16,
    parameter int CHANNELS    = 2**SEL_WIDTH
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic [SEL_WIDTH-1:0]           in_key,
    input  logic                           in_broadcast,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]            out_valid,
    input  logic [CHANNELS-1:0]            out_ready,
    output logic [COUNT_WIDTH-1:0]         accepted_count
);

    logic [CHANNELS-1:0] free;
    logic [CHANNELS-1:0] load;
    logic                accept;

    // A full slot being drained this cycle can take a new word in the same
    // cycle, so each channel sustains one word per clock.
    assign free = ~out_valid | out_ready;

    always_comb begin
        in_ready = 1'b0;
        if (!reset && enable) begin
            if (in_broadcast)
                in_ready = &free;
            else
                in_ready = free[in_key];
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        load = '0;
        for (int i = 0; i < CHANNELS; i++)
            load[i] = accept && (in_broadcast || (in_key == SEL_WIDTH'(i)));
    end

    // Reload takes priority over drain so a simultaneous drain and reload
    // keeps the slot full with the new word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid      <= '0;
            out_data       <= '0;
            accepted_count <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (load[i]) begin
                    out_valid[i]                          <= 1'b1;
                    out_data[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
            if (accept)
                accepted_count <= accepted_count + COUNT_WIDTH'(1);
        end
    end

endmodule
